median_binarize: RTL

Upstream pre-processing stage of the denoise/edge-detect pipeline. It reads the 128x128 8-bit grayscale source image and applies a 3x3 zero-padded median filter to each pixel. It then thresholds the median to 1 bit and writes the result to the binary image memory. The Laplacian convolution stage reads that memory one bit at a time.

---
 rtl/median_binarize_pkg.sv | 40 ++++
 rtl/median9_sort.sv | 40 ++++
 rtl/median_binarize.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/median_binarize_pkg.sv
// Shared definitions for the median/binarize stage and the convolution stage
// that reads its output: image geometry, FSM encoding, 3x3 neighbour table and
// border predicates.
package median_binarize_pkg;

  localparam int IMG_LOG2 = 7;
  localparam int PIX_W    = 8;
  localparam int NB_CNT   = 9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  // Column offset of neighbour k (row-major scan of the 3x3 window).
  function automatic int nb_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: nb_dx = -1;
      4'd1, 4'd4, 4'd7: nb_dx = 0;
      default:          nb_dx = 1;
    endcase
  endfunction

  // Row offset of neighbour k.
  function automatic int nb_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: nb_dy = -1;
      4'd3, 4'd4, 4'd5: nb_dy = 0;
      default:          nb_dy = 1;
    endcase
  endfunction

  // True when coordinate c shifted by d stays inside an n-wide axis.
  function automatic logic nb_inside(input int c, input int d, input int n);
    nb_inside = ((c + d) >= 0) && ((c + d) < n);
  endfunction

endpackage

// File: rtl/median9_sort.sv
// Nine-entry ascending register array. Each insert places the new sample in
// order and drops the current largest entry, so after nine inserts on a
// preloaded all-ones array it holds exactly the nine samples.
module median9_sort #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_insert,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_med_ins
);

  logic [8:0][PIX_W-1:0] r_s;
  logic [8:0][PIX_W-1:0] w_ins;

  // Next array contents if i_din is inserted this cycle.
  always_comb begin
    w_ins    = r_s;
    w_ins[0] = (r_s[0] <= i_din) ? r_s[0] : i_din;
    for (int i = 1; i < 9; i++) begin
      if (r_s[i] <= i_din)        w_ins[i] = r_s[i];
      else if (r_s[i-1] <= i_din) w_ins[i] = i_din;
      else                        w_ins[i] = r_s[i-1];
    end
  end

  // Preload with all-ones per pixel, otherwise insert on request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_s <= '1;
    else if (i_clear)  r_s <= '1;
    else if (i_insert) r_s <= w_ins;
  end

  // Entry 4 as it will be after this cycle's insert; lets the final insert and
  // the registered binarized output share one edge.
  assign o_med_ins = w_ins[4];

endmodule

// File: rtl/median_binarize.sv
// 3x3 zero-padded median filter plus threshold over a square grayscale image,
// one pixel every 11 cycles (10 FETCH + 1 WRITE).
module median_binarize #(
  parameter int IMG_LOG2 = median_binarize_pkg::IMG_LOG2,
  parameter int PIX_W    = median_binarize_pkg::PIX_W,
  parameter int THRESH   = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [2*IMG_LOG2-1:0] m_addr,
  output logic                  m_rd,
  input  logic [PIX_W-1:0]      m_di,
  output logic [2*IMG_LOG2-1:0] b_addr,
  output logic                  b_wr,
  output logic                  b_do,
  output logic                  busy,
  output logic                  done
);

  import median_binarize_pkg::*;

  localparam int N  = 1 << IMG_LOG2;
  localparam int AW = 2 * IMG_LOG2;
  localparam logic [PIX_W-1:0] TH = PIX_W'(THRESH);

  state_e                r_state;
  logic [IMG_LOG2-1:0]   r_x, r_y;
  logic [3:0]            r_k;
  logic                  r_rd_d;
  logic [AW-1:0]         r_m_addr, r_b_addr;
  logic                  r_m_rd, r_b_wr, r_b_do, r_busy, r_done;

  logic [IMG_LOG2-1:0]   w_x_nxt, w_y_nxt, w_sx, w_sy;
  logic [3:0]            w_sk;
  logic [AW:0]           w_slot;
  logic                  w_srd, w_last;
  logic [PIX_W-1:0]      w_din, w_med_ins;
  logic                  w_clear, w_insert;

  // {inside, address} of neighbour ck around pixel (cx, cy).
  function automatic logic [AW:0] slot(input logic [IMG_LOG2-1:0] cx,
                                       input logic [IMG_LOG2-1:0] cy,
                                       input logic [3:0]          ck);
    int dx, dy;
    logic in;
    dx = nb_dx(ck);
    dy = nb_dy(ck);
    in = nb_inside(int'(cx), dx, N) && nb_inside(int'(cy), dy, N);
    slot = {in, IMG_LOG2'(int'(cy) + dy), IMG_LOG2'(int'(cx) + dx)};
  endfunction

  assign w_x_nxt = r_x + 1'b1;
  assign w_y_nxt = (&r_x) ? r_y + 1'b1 : r_y;
  assign w_last  = (&r_x) && (&r_y);

  // Pick which slot the read strobe registered at this edge belongs to.
  always_comb begin
    w_sx = r_x;
    w_sy = r_y;
    w_sk = r_k + 4'd1;
    case (r_state)
      S_IDLE:  begin w_sx = '0;      w_sy = '0;      w_sk = '0; end
      S_WRITE: begin w_sx = w_x_nxt; w_sy = w_y_nxt; w_sk = '0; end
      default: ;
    endcase
  end

  assign w_slot = slot(w_sx, w_sy, w_sk);
  assign w_srd  = w_slot[AW] && (w_sk < 4'd9);

  // Read data lands one cycle after the strobe; padding slots contribute 0.
  assign w_din    = r_rd_d ? m_di : '0;
  assign w_clear  = (r_state == S_FETCH) && (r_k == 4'd0);
  assign w_insert = (r_state == S_FETCH) && (r_k != 4'd0);

  median9_sort #(.PIX_W(PIX_W)) u_sort (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_insert  (w_insert),
    .i_din     (w_din),
    .o_med_ins (w_med_ins)
  );

  // Frame FSM, coordinate counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_rd_d   <= 1'b0;
      r_m_addr <= '0;
      r_m_rd   <= 1'b0;
      r_b_addr <= '0;
      r_b_wr   <= 1'b0;
      r_b_do   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rd_d <= r_m_rd;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_x     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_m_rd  <= w_srd;
            if (w_srd) r_m_addr <= w_slot[AW-1:0];
          end
        end
        S_FETCH: begin
          if (r_k == 4'd9) begin
            r_state  <= S_WRITE;
            r_m_rd   <= 1'b0;
            r_b_wr   <= 1'b1;
            r_b_addr <= {r_y, r_x};
            r_b_do   <= (w_med_ins >= TH);
          end else begin
            r_k    <= r_k + 4'd1;
            r_m_rd <= w_srd;
            if (w_srd) r_m_addr <= w_slot[AW-1:0];
          end
        end
        S_WRITE: begin
          r_b_wr <= 1'b0;
          if (w_last) begin
            r_state <= S_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_k     <= '0;
            r_m_rd  <= w_srd;
            if (w_srd) r_m_addr <= w_slot[AW-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_addr = r_m_addr;
  assign m_rd   = r_m_rd;
  assign b_addr = r_b_addr;
  assign b_wr   = r_b_wr;
  assign b_do   = r_b_do;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
